// File: rtl/av_mm_arb_pkg.sv
// rtl/av_mm_arb_pkg.sv - shared types and round-robin helper for Avalon-MM arbiters
//
// Contents:
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, RDWAIT, RDRET)
//   MAX_REQ     : widest request vector rr_next can search
//   MAX_PTR_W   : index width matching MAX_REQ
//   LAT_W       : width of the read latency counter (RD_LATENCY up to 4)
//   rr_next     : first set request at or after a pointer, wrapping modulo n

package av_mm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RDRET  = 2'd3
  } arb_state_t;

  localparam int MAX_REQ   = 16;
  localparam int MAX_PTR_W = 4;
  localparam int LAT_W     = 2;

  // Walks the candidates from farthest to nearest so the one closest to ptr
  // (in wrap order) is the last assignment and therefore wins. Only the first
  // n bits of req take part. With no request set the pointer is returned.
  function automatic logic [MAX_PTR_W-1:0] rr_next(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_PTR_W-1:0] ptr,
    input int                   n
  );
    logic [MAX_PTR_W-1:0] g;
    int                   idx;
    g = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (req[idx[MAX_PTR_W-1:0]]) begin
          g = idx[MAX_PTR_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/av_mm_rr_arbiter_rr_pick.sv
// rtl/av_mm_rr_arbiter_rr_pick.sv - combinational round-robin selector
//
// Ports:
//   req     in  [N]   request vector, bit i = requester i wants service
//   ptr     in  [GW]  search start index (highest priority this round)
//   grant   out [GW]  index of the first set request at or after ptr
//   any_req out 1     at least one request is set; grant is meaningless if 0

module rr_pick
  import av_mm_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] grant,
  output logic          any_req
);

  logic [MAX_REQ-1:0]   req_ext;
  logic [MAX_PTR_W-1:0] ptr_ext;
  logic [MAX_PTR_W-1:0] grant_ext;

  assign req_ext   = MAX_REQ'(req);
  assign ptr_ext   = MAX_PTR_W'(ptr);
  assign grant_ext = rr_next(req_ext, ptr_ext, N);
  assign grant     = grant_ext[GW-1:0];
  assign any_req   = |req;

endmodule

// File: rtl/av_mm_rr_arbiter.sv
// rtl/av_mm_rr_arbiter.sv - round-robin arbiter sharing one Avalon-MM slave
//
// Serialises NUM_REQ Avalon-MM requesters onto a single fixed-latency master
// port, one transfer in flight, and steers read data back to the requester
// that issued it.
//
// Ports:
//   clk_i             in  1             clock
//   reset_i           in  1             synchronous active-high reset
//   req_address       in  [NUM_REQ][AW] per-requester word address
//   req_byteenable    in  [NUM_REQ][BE] per-requester byte enables
//   req_read          in  [NUM_REQ]     read request (level held)
//   req_write         in  [NUM_REQ]     write request (level held)
//   req_writedata     in  [NUM_REQ][DW] write data
//   req_waitrequest   out [NUM_REQ]     low for one cycle when the command is taken
//   req_readdata      out [DW]          shared read data, held until next capture
//   req_readdatavalid out [NUM_REQ]     one-cycle strobe to the reading requester
//   avm_address       out [AW]          master address
//   avm_byteenable    out [BE]          master byte enables
//   avm_read          out 1             master read strobe
//   avm_write         out 1             master write strobe
//   avm_writedata     out [DW]          master write data
//   avm_readdata      in  [DW]          slave data, RD_LATENCY cycles after avm_read

module av_mm_rr_arbiter
  import av_mm_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0][AW-1:0]    req_address,
  input  logic [NUM_REQ-1:0][DW/8-1:0]  req_byteenable,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0][DW-1:0]    req_writedata,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [DW-1:0]                 req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  output logic [AW-1:0]                 avm_address,
  output logic [DW/8-1:0]               avm_byteenable,
  output logic                          avm_read,
  output logic                          avm_write,
  output logic [DW-1:0]                 avm_writedata,
  input  logic [DW-1:0]                 avm_readdata
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state;
  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       grant;
  logic [LAT_W-1:0]    lat_cnt;

  logic [NUM_REQ-1:0]  req_vec;
  logic [GW-1:0]       pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [GW-1:0]       ptr_after_grant;

  assign req_vec      = req_read | req_write;
  assign pick_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;

  // Pointer moves just past the winner so it has lowest priority next round.
  assign ptr_after_grant = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  rr_pick #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_rr_pick (
    .req     (req_vec),
    .ptr     (rr_ptr),
    .grant   (pick_idx),
    .any_req (pick_any)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant             <= '0;
      lat_cnt           <= '0;
      avm_address       <= '0;
      avm_byteenable    <= '0;
      avm_read          <= 1'b0;
      avm_write         <= 1'b0;
      avm_writedata     <= '0;
      req_waitrequest   <= '1;
      req_readdata      <= '0;
      req_readdatavalid <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_readdatavalid <= '0;
          if (pick_any) begin
            // The whole command is latched here, so a requester that drops
            // its request before ISSUE still has it carried out.
            grant           <= pick_idx;
            avm_address     <= req_address[pick_idx];
            avm_byteenable  <= req_byteenable[pick_idx];
            avm_writedata   <= req_writedata[pick_idx];
            // Write has precedence when a requester asserts both strobes.
            avm_write       <= req_write[pick_idx];
            avm_read        <= req_read[pick_idx] & ~req_write[pick_idx];
            req_waitrequest <= ~pick_onehot;
            state           <= ISSUE;
          end
        end

        ISSUE: begin
          avm_read        <= 1'b0;
          avm_write       <= 1'b0;
          req_waitrequest <= '1;
          rr_ptr          <= ptr_after_grant;
          if (avm_read) begin
            lat_cnt <= LAT_W'(RD_LATENCY - 1);
            state   <= RDWAIT;
          end else begin
            state <= IDLE;
          end
        end

        RDWAIT: begin
          if (lat_cnt == '0) begin
            req_readdata      <= avm_readdata;
            req_readdatavalid <= grant_onehot;
            state             <= RDRET;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        RDRET: begin
          req_readdatavalid <= '0;
          state             <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_av_mm_rr_arbiter.sv
// tb/tb_av_mm_rr_arbiter.sv - scoreboard bench for av_mm_rr_arbiter

module tb_av_mm_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int RD_LAT  = 1;
  localparam int BW      = DW / 8;
  localparam int RD_GAP  = 3 + RD_LAT;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                        reset_i;
  logic [NUM_REQ-1:0][AW-1:0]  req_address;
  logic [NUM_REQ-1:0][BW-1:0]  req_byteenable;
  logic [NUM_REQ-1:0]          req_read;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ-1:0][DW-1:0]  req_writedata;
  logic [NUM_REQ-1:0]          req_waitrequest;
  logic [DW-1:0]               req_readdata;
  logic [NUM_REQ-1:0]          req_readdatavalid;
  logic [AW-1:0]               avm_address;
  logic [BW-1:0]               avm_byteenable;
  logic                        avm_read;
  logic                        avm_write;
  logic [DW-1:0]               avm_writedata;
  logic [DW-1:0]               avm_readdata;

  av_mm_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DW         (DW),
    .AW         (AW),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .req_address       (req_address),
    .req_byteenable    (req_byteenable),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata)
  );

  // Slave model: 16-word register file with fixed read latency.
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  bit            mem_loaded;

  always @(posedge clk_i) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[1]     <= 32'h9183_8491;
      mem[2]     <= 32'h5a5a_5a5a;
      mem[4]     <= 32'h1111_0004;
      mem[5]     <= 32'h2222_0005;
      mem[6]     <= 32'h3333_0006;
      mem[7]     <= 32'h4444_0007;
      mem[8]     <= 32'h5555_0008;
      mem_loaded <= 1'b1;
    end else if (avm_write) begin
      for (int b = 0; b < BW; b++)
        if (avm_byteenable[b]) mem[avm_address[3:0]][b*8 +: 8] <= avm_writedata[b*8 +: 8];
    end
    rd_pipe[0] <= avm_read ? mem[avm_address[3:0]] : 32'hdead_beef;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign avm_readdata = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            idx;
    bit            wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
    int            cyc;
  } grant_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            cyc;
  } rdat_t;

  grant_t gq[$];
  rdat_t  dq[$];

  task automatic exp_grant(input int idx, input bit wr, input logic [AW-1:0] addr,
                           input logic [BW-1:0] be, input logic [DW-1:0] data, input int c);
    grant_t g;
    g.idx = idx; g.wr = wr; g.addr = addr; g.be = be; g.data = data; g.cyc = c;
    gq.push_back(g);
  endtask

  task automatic exp_read(input int idx, input logic [DW-1:0] data, input int c);
    rdat_t d;
    d.idx = idx; d.data = data; d.cyc = c;
    dq.push_back(d);
  endtask

  // Monitor: pops an expectation whenever the DUT shows a grant or read strobe.
  grant_t             mg;
  rdat_t              md;
  logic [NUM_REQ-1:0] exp_vec;

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (req_waitrequest != '1 || avm_read || avm_write) begin
        total++;
        if (gq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_grant: got wreq=%b rd=%0b wr=%0b expected no grant (cycle %0d)",
                   req_waitrequest, avm_read, avm_write, cyc);
        end else begin
          mg = gq.pop_front();
          exp_vec = ~(NUM_REQ'(1) << mg.idx);
          check("grant_waitrequest", req_waitrequest, exp_vec);
          check("grant_cycle", cyc, mg.cyc);
          check("grant_avm_write", avm_write, mg.wr);
          check("grant_avm_read", avm_read, !mg.wr);
          check("grant_address", avm_address, mg.addr);
          check("grant_byteenable", avm_byteenable, mg.be);
          if (mg.wr) check("grant_writedata", avm_writedata, mg.data);
        end
      end
      if (req_readdatavalid != '0) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_readdatavalid: got %b expected 0 (cycle %0d)",
                   req_readdatavalid, cyc);
        end else begin
          md = dq.pop_front();
          exp_vec = NUM_REQ'(1) << md.idx;
          check("rdv_vector", req_readdatavalid, exp_vec);
          check("rdv_data", req_readdata, md.data);
          check("rdv_cycle", cyc, md.cyc);
        end
      end
    end
  end

  // Holds a request until the DUT takes it, then drops it after that edge.
  task automatic drive(input int idx, input bit rd, input bit wr, input logic [AW-1:0] addr,
                       input logic [BW-1:0] be, input logic [DW-1:0] data);
    bit got;
    req_address[idx]    = addr;
    req_byteenable[idx] = be;
    req_writedata[idx]  = data;
    req_read[idx]       = rd;
    req_write[idx]      = wr;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk_i);
      if (!req_waitrequest[idx]) got = 1;
    end
    check($sformatf("accept_req%0d", idx), got, 1'b1);
    @(posedge clk_i);
    #1;
    req_read[idx]  = 1'b0;
    req_write[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk_i);
      if (gq.size() == 0 && dq.size() == 0) done = 1;
    end
    check("drain", done, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_waitrequest"}, req_waitrequest, {NUM_REQ{1'b1}});
    check({tag, "_avm_read"}, avm_read, 1'b0);
    check({tag, "_avm_write"}, avm_write, 1'b0);
    check({tag, "_readdatavalid"}, req_readdatavalid, '0);
  endtask

  logic [DW-1:0] four_data [0:4];
  int c0;
  int c1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i        = 1'b1;
    req_address    = '0;
    req_byteenable = '0;
    req_read       = '0;
    req_write      = '0;
    req_writedata  = '0;
    four_data[0] = 32'h1111_0004;
    four_data[1] = 32'h2222_0005;
    four_data[2] = 32'h3333_0006;
    four_data[3] = 32'h4444_0007;
    four_data[4] = 32'h5555_0008;

    // Reset state, held and after release with no requests.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_outputs("reset");
    check("reset_readdata", req_readdata, '0);
    check("reset_address", avm_address, '0);
    check("reset_byteenable", avm_byteenable, '0);
    check("reset_writedata", avm_writedata, '0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      check_idle_outputs("idle");
    end
    @(posedge clk_i);
    #1;

    // Requester 2 write, then requester 0 reads it back.
    c0 = cyc;
    exp_grant(2, 1, 16'h0, 4'hF, 32'habcd_4526, c0 + 1);
    drive(2, 0, 1, 16'h0, 4'hF, 32'habcd_4526);
    c1 = cyc;
    check("write_release_cycle", c1, c0 + 2);
    exp_grant(0, 0, 16'h0, 4'hF, '0, c1 + 1);
    exp_read(0, 32'habcd_4526, c1 + 2 + RD_LAT);
    drive(0, 1, 0, 16'h0, 4'hF, '0);
    wait_drain();

    // Requester 1 reads preloaded word.
    c0 = cyc;
    exp_grant(1, 0, 16'h1, 4'hF, '0, c0 + 1);
    exp_read(1, 32'h9183_8491, c0 + 2 + RD_LAT);
    drive(1, 1, 0, 16'h1, 4'hF, '0);
    wait_drain();

    // All four read from reset release; requester 0 keeps requesting.
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_grant(k, 0, AW'(4 + k), 4'hF, '0, c0 + 1 + k * RD_GAP);
      exp_read(k, four_data[k], c0 + 2 + RD_LAT + k * RD_GAP);
    end
    exp_grant(0, 0, 16'h8, 4'hF, '0, c0 + 1 + 4 * RD_GAP);
    exp_read(0, four_data[4], c0 + 2 + RD_LAT + 4 * RD_GAP);
    fork
      begin
        drive(0, 1, 0, 16'h4, 4'hF, '0);
        drive(0, 1, 0, 16'h8, 4'hF, '0);
      end
      drive(1, 1, 0, 16'h5, 4'hF, '0);
      drive(2, 1, 0, 16'h6, 4'hF, '0);
      drive(3, 1, 0, 16'h7, 4'hF, '0);
    join
    wait_drain();

    // Read and write together: only the write goes out; top byte only.
    c0 = cyc;
    exp_grant(3, 1, 16'h2, 4'h8, 32'h3456_aabb, c0 + 1);
    drive(3, 1, 1, 16'h2, 4'h8, 32'h3456_aabb);
    repeat (3) begin
      @(negedge clk_i);
      check("rw_no_readdatavalid", req_readdatavalid, '0);
    end
    @(posedge clk_i);
    #1;
    c1 = cyc;
    exp_grant(3, 0, 16'h2, 4'hF, '0, c1 + 1);
    exp_read(3, 32'h345a_5a5a, c1 + 2 + RD_LAT);
    drive(3, 1, 0, 16'h2, 4'hF, '0);
    wait_drain();

    // Reset during RDWAIT: read discarded, pointer back to 0.
    c0 = cyc;
    exp_grant(1, 0, 16'h1, 4'hF, '0, c0 + 1);
    drive(1, 1, 0, 16'h1, 4'hF, '0);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      check_idle_outputs("post_reset");
    end
    @(posedge clk_i);
    #1;
    c0 = cyc;
    exp_grant(0, 0, 16'h4, 4'hF, '0, c0 + 1);
    exp_read(0, four_data[0], c0 + 2 + RD_LAT);
    exp_grant(3, 0, 16'h7, 4'hF, '0, c0 + 1 + RD_GAP);
    exp_read(3, four_data[3], c0 + 2 + RD_LAT + RD_GAP);
    fork
      drive(0, 1, 0, 16'h4, 4'hF, '0);
      drive(3, 1, 0, 16'h7, 4'hF, '0);
    join
    wait_drain();

    check("final_grant_queue", gq.size(), 0);
    check("final_read_queue", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/av_mm_rr_arbiter.md
# av_mm_rr_arbiter

Round-robin arbiter that shares one Avalon-MM slave, normally `av_univ_regs`, between NUM_REQ Avalon-MM requesters. Each requester sees a slave port with waitrequest and readdatavalid. The arbiter drives a single master port with fixed read latency into the register file. It serialises accesses, one transfer in flight at a time, and routes read data back to the originating requester.

## Interface
- NUM_REQ, 4, number of requester ports (2..16)
- DW, 32, data width; byteenable width is DW/8
- AW, 16, word address width
- RD_LATENCY, 1, slave read latency in cycles from avm_read to valid avm_readdata (1..4)
- clk_i  in  1  single clock; all logic rises on clk_i
- reset_i  in  1  reset, synchronous, active-high
- req_address  in  [NUM_REQ][AW]  per-requester address
- req_byteenable  in  [NUM_REQ][DW/8]  per-requester byte enables
- req_read  in  [NUM_REQ]  read request
- req_write  in  [NUM_REQ]  write request
- req_writedata  in  [NUM_REQ][DW]  write data
- req_waitrequest  out  [NUM_REQ]  high = command not accepted; reset value all ones
- req_readdata  out  [DW]  shared read data bus; reset value 0
- req_readdatavalid  out  [NUM_REQ]  one-cycle read-data strobe; reset value 0
- avm_address  out  AW  to slave; reset value 0
- avm_byteenable  out  DW/8  to slave; reset value 0
- avm_read  out  1  to slave; reset value 0
- avm_write  out  1  to slave; reset value 0
- avm_writedata  out  DW  to slave; reset value 0
- avm_readdata  in  DW  from slave, valid RD_LATENCY cycles after avm_read

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, RDRET.
- IDLE:
  - request vector r[i] = req_read[i] | req_write[i].
  - If r ≠ 0, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ. That index is grant g.
  - Latch req_address/byteenable/writedata of g into the avm_* registers.
  - avm_write = req_write[g]. avm_read = req_read[g] & ~req_write[g]. Write wins if both are asserted.
  - Go to ISSUE.
- ISSUE:
  - avm_read/avm_write are high for exactly this cycle.
  - req_waitrequest[g] = 0 this cycle only, which completes the requester transfer.
  - rr_ptr ← (g+1) mod NUM_REQ.
  - Write: next state is IDLE. Read: next state is RDWAIT, with the latency counter loaded to RD_LATENCY-1.
- RDWAIT:
  - Counter decrements each cycle.
  - When the counter reaches 0, capture avm_readdata into req_readdata and go to RDRET.
- RDRET:
  - req_readdatavalid[g] = 1 for one cycle.
  - Then go to IDLE.
  - req_readdata holds its value until the next read capture.
- req_waitrequest is high for every requester in every state except as stated for ISSUE.
- Requests are level-held by Avalon rule. A requester that drops its request before ISSUE still gets its latched command executed.
- Reset mid-operation:
  - State → IDLE, rr_ptr → 0.
  - All outputs take their reset values.
  - In-flight read data is discarded; no readdatavalid is issued.

## Timing
- Arbitration decision is registered. Requester asserts at cycle 0 with the arbiter idle: avm strobe and waitrequest low at cycle 1.
- Write: cycles 0–1. Next grant can be issued at cycle 3, so throughput is one write per 2 cycles.
- Read: readdata captured at the end of cycle 1+RD_LATENCY. readdatavalid at cycle 2+RD_LATENCY.
- Read throughput is one read per 3+RD_LATENCY cycles.
- Starvation bound: a holding requester is granted within NUM_REQ-1 other transfers.
- At most one of req_readdatavalid is high in any cycle, and only after that requester's own ISSUE cycle.

## Structure
- Package av_mm_arb_pkg holds:
  - state enum arb_state_t (IDLE, ISSUE, RDWAIT, RDRET)
  - function rr_next(req, ptr), returning the grant index
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: request vector and pointer.
  - Outputs: grant index and any_req.
  - Reusable by other arbiters.
- Top level holds the FSM, rr_ptr, latency counter, and avm_*/readdata registers.

## Test plan
- Reset, then release; no requests. All waitrequest stay 1, avm_read and avm_write stay 0, readdatavalid stays 0.
- Requester 2 writes 0xabcd4526 to addr 0 with be 0xF. One ISSUE cycle on avm_write, then waitrequest[2] low for one cycle. A following read by requester 0 of addr 0 returns 0xabcd4526 with readdatavalid[0] at cycle 2+RD_LATENCY.
- Requester 1 reads addr 1 of a slave initialised to 0x91838491. readdatavalid[1] is the only strobe, and req_readdata = 0x91838491.
- Requesters 0–3 all hold reads from reset release. Grants occur in order 0,1,2,3, then 0 again if still requesting, each read spaced 3+RD_LATENCY cycles.
- Requester 3 asserts read and write together to addr 2, data 0x3456aabb, be 0x8. Only the write is issued, no readdatavalid follows, and reading back gives 0x34xxxxxx in the top byte.
- reset_i pulsed during RDWAIT of a read. No readdatavalid follows, rr_ptr returns to 0, and the next request from requester 0 is granted first.
